// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: out_clk period is 2*cur_half orgin_clk cycles, 50% duty.
// Half-period changes and stops happen only on a falling toggle, so high phases are never cut or stretched.
module clk_div_ctrl #(
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 2
) (
    input  logic             orgin_clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             out_clk,
    output logic             active,
    output logic             busy
);

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cur_half;
    logic [CNT_W-1:0] pend_half;
    logic             pend_vld;

    logic             counting;
    logic             toggle;
    logic             fall_toggle;
    logic             handshake;
    logic             apply;

    // cur_half is never 0 (a zero request is stored as 1), so cur_half-1 cannot wrap.
    assign counting    = (state != STOP);
    assign toggle      = counting && (cnt == (cur_half - CNT_W'(1)));
    assign fall_toggle = toggle && out_clk;
    assign handshake   = cfg_valid && !pend_vld;
    assign apply       = pend_vld && ((state == STOP) || fall_toggle);

    always_ff @(posedge orgin_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= STOP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            STOP: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_nxt = RUN;
                end else if (fall_toggle) begin
                    state_nxt = STOP;
                end
            end
            default: state_nxt = STOP;
        endcase
    end

    always_comb begin
        active    = (state != STOP);
        busy      = pend_vld;
        cfg_ready = !pend_vld;
    end

    // A falling toggle already returns cnt to 0, so an apply there needs no extra clear.
    always_ff @(posedge orgin_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_clk   <= 1'b0;
            cnt       <= '0;
            cur_half  <= CNT_W'(DEF_HALF);
            pend_half <= '0;
            pend_vld  <= 1'b0;
        end else begin
            if (handshake) begin
                pend_half <= (cfg_half == '0) ? CNT_W'(1) : cfg_half;
                pend_vld  <= 1'b1;
            end else if (apply) begin
                pend_vld  <= 1'b0;
            end

            if (apply) begin
                cur_half <= pend_half;
            end

            if (!counting) begin
                cnt     <= '0;
                out_clk <= 1'b0;
            end else if (toggle) begin
                cnt     <= '0;
                out_clk <= !out_clk;
            end else begin
                cnt     <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the half-period count and config value.
REQ-002 Parameter DEF_HALF, default 2: half-period (source cycles) loaded at reset, giving divide-by-4.
REQ-003 orgin_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  run request; level-sensitive.
REQ-006 cfg_valid  input  1  new half-period offered on cfg_half.
REQ-007 cfg_half  input  CNT_W  requested half-period in orgin_clk cycles.
REQ-008 cfg_ready  output  1  config slot free; transfer on cfg_valid&cfg_ready at a rising edge.
REQ-009 out_clk  output  1  divided clock, driven directly from a flop.
REQ-010 active  output  1  high whenever state is not STOP.
REQ-011 busy  output  1  high while an accepted config is pending, not yet applied.

Function
REQ-012 Registers: state {STOP, RUN, DRAIN}, cnt[CNT_W], cur_half[CNT_W], pend_half[CNT_W], pend_vld.
REQ-013 Accepted cfg_half=0 is stored as 1; any other value is stored unchanged.
REQ-014 cfg_ready = ~pend_vld; busy = pend_vld; both combinational from registers only.
REQ-015 On handshake: pend_half <= cfg_half (after REQ-013), pend_vld <= 1.
REQ-016 Apply event: cur_half <= pend_half, pend_vld <= 0, cnt <= 0; no handshake possible in the same cycle because cfg_ready=0.
REQ-017 STOP: out_clk=0, cnt=0; if pend_vld, apply on the next edge regardless of en.
REQ-018 STOP->RUN on the edge where en=1; cnt starts counting from 0 that cycle; a pending config applied in the same edge takes effect for the first half-period.
REQ-019 RUN/DRAIN counting: if cnt == cur_half-1, then cnt <= 0 and out_clk <= ~out_clk; else cnt <= cnt+1.
REQ-020 Output period = 2*cur_half orgin_clk cycles, 50% duty; first rising out_clk edge occurs cur_half cycles after leaving STOP.
REQ-021 Falling toggle = a toggle with out_clk currently 1.
REQ-022 In RUN/DRAIN, a pending config is applied only on a falling toggle; high phases are never shortened or stretched.
REQ-023 RUN->DRAIN when en=0; DRAIN->RUN when en=1 again, with no interruption of counting.
REQ-024 DRAIN->STOP on a falling toggle; out_clk ends at 0, cnt <= 0; a pending config applies on that same edge.
REQ-025 If en=0 while out_clk=0 in RUN, the block still completes the current low phase and next high phase before stopping (no runt pulses).
REQ-026 Handshake accepted in any state, including the cycle of a falling toggle, provided pend_vld was 0 before that edge.
REQ-027 cnt compare is unsigned at width CNT_W; cur_half=2**CNT_W-1 is legal with no overflow.

Reset
REQ-028 reset_n low asynchronously forces state=STOP, out_clk=0, cnt=0, cur_half=DEF_HALF, pend_half=0, pend_vld=0.
REQ-029 Outputs after reset: out_clk=0, active=0, busy=0, cfg_ready=1.
REQ-030 Reset mid-operation discards any pending config and truncates out_clk immediately; this is the only permitted glitch path.

Verification
REQ-031 Reset release, en=1, no config -> out_clk toggles every 2 cycles, period 4, first rise 2 cycles after RUN entry.
REQ-032 STOP, cfg_half=5 handshake, then en=1 -> busy high 1 cycle, period 10, high and low phases each 5 cycles.
REQ-033 RUN at half=2, cfg_half=7 accepted while out_clk=1 -> current high phase stays 2 cycles, the switch occurs at the falling toggle, and subsequent phases are 7 cycles; cfg_ready=0 until the switch.
REQ-034 RUN, en dropped during the low phase -> one full high phase completes, then out_clk=0, active=0; en reasserted in DRAIN -> no gap in toggling.
REQ-035 cfg_half=0 accepted -> period 2; second cfg_valid while busy -> not accepted, cfg_half ignored until cfg_ready=1.
REQ-036 reset_n asserted while out_clk=1 with config pending -> out_clk=0 same cycle (asynchronous), busy=0, and the next run uses half=DEF_HALF.
